// File: rtl/gcd_pkg.sv
// Shared types and constants for the binary GCD / modular-inverse engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_GCD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  // Upper bound on ALIGN plus RUN cycles for one request.
  function automatic int max_iter(input int width);
    return 5 * width + 2;
  endfunction

endpackage

// File: rtl/gcd_modinv_if.sv
// Request/response bundle between a requester and the gcd_modinv engine.
interface gcd_modinv_if #(
  parameter int WIDTH = 16
);
  logic             iValid;
  logic             iMode;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oReady;
  logic             oValid;
  logic [WIDTH-1:0] oC;
  logic             oErr;

  modport master (
    output iValid, iMode, iA, iB,
    input  oReady, oValid, oC, oErr
  );

  modport slave (
    input  iValid, iMode, iA, iB,
    output oReady, oValid, oC, oErr
  );
endinterface

// File: rtl/gcd_coef_unit.sv
// Combinational Bezout-coefficient helpers: halving and subtraction modulo an odd B.
module gcd_coef_unit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] half1,
  output logic [WIDTH-1:0] half2,
  output logic [WIDTH-1:0] sub12,
  output logic [WIDTH-1:0] sub21
);

  // Odd x gets B added first so the sum is even; the carry needs the extra bit.
  function automatic logic [WIDTH-1:0] halfmod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  function automatic logic [WIDTH-1:0] submod(input logic [WIDTH-1:0] p,
                                              input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    d = {1'b0, p} - {1'b0, q};
    if (d[WIDTH]) begin
      d = d + {1'b0, m};
    end
    return d[WIDTH-1:0];
  endfunction

  always_comb begin
    half1 = halfmod(x1, b);
    half2 = halfmod(x2, b);
    sub12 = submod(x1, x2, b);
    sub21 = submod(x2, x1, b);
  end

endmodule

// File: rtl/gcd_modinv.sv
// Iterative binary GCD (Stein) and binary extended-Euclid modular inverse,
// one reduction step per clock behind a valid/ready request handshake.
module gcd_modinv
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic         iClk,
  input  logic         iRst,
  gcd_modinv_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [CNTW-1:0]  k_q, k_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] half1, half2, sub12, sub21;
  logic [WIDTH-1:0] g;
  logic             u_zero, v_zero, inv_bad;

  gcd_coef_unit #(.WIDTH(WIDTH)) u_coef (
    .x1    (x1_q),
    .x2    (x2_q),
    .b     (b_q),
    .half1 (half1),
    .half2 (half2),
    .sub12 (sub12),
    .sub21 (sub21)
  );

  assign u_zero = (u_q == '0);
  assign v_zero = (v_q == '0);
  assign g      = u_zero ? v_q : u_q;
  assign inv_bad = (g != WIDTH'(1));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      b_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      mode_q  <= MODE_GCD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      b_q     <= b_d;
      c_q     <= c_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    b_d     = b_q;
    c_d     = c_q;
    k_d     = k_q;
    mode_d  = mode_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.iValid) begin
          u_d    = bus.iA;
          v_d    = bus.iB;
          b_d    = bus.iB;
          k_d    = '0;
          x1_d   = WIDTH'(1);
          x2_d   = '0;
          mode_d = bus.iMode;
          if (bus.iMode == MODE_GCD) begin
            state_d = ALIGN;
          end else if (!bus.iB[0] || (bus.iB < WIDTH'(2))) begin
            // An even or trivial modulus never has an inverse; skip the loop.
            state_d = DONE;
            err_d   = 1'b1;
            c_d     = '0;
          end else begin
            state_d = RUN;
          end
        end
      end

      ALIGN: begin
        if (u_zero || v_zero || u_q[0] || v_q[0]) begin
          state_d = RUN;
        end else begin
          u_d = u_q >> 1;
          v_d = v_q >> 1;
          k_d = k_q + CNTW'(1);
        end
      end

      RUN: begin
        if (u_zero || v_zero) begin
          state_d = DONE;
          if (mode_q == MODE_INV) begin
            err_d = inv_bad;
            c_d   = inv_bad ? '0 : (u_zero ? x2_q : x1_q);
          end else begin
            err_d = 1'b0;
            c_d   = g << k_q;
          end
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = half1;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = half2;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub12;
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub21;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.oReady = (state_q == IDLE);
    bus.oValid = (state_q == DONE);
    bus.oC     = c_q;
    bus.oErr   = err_q;
  end

endmodule

// File: tb/tb_gcd_modinv.sv
// Directed and randomized checks of gcd_modinv at WIDTH=16 and WIDTH=32.
module tb_gcd_modinv;
  import gcd_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   acc    = 0;

  gcd_modinv_if #(.WIDTH(16)) if16 ();
  gcd_modinv_if #(.WIDTH(32)) if32 ();

  gcd_modinv #(.WIDTH(16)) dut16 (.iClk(clk), .iRst(rst), .bus(if16));
  gcd_modinv #(.WIDTH(32)) dut32 (.iClk(clk), .iRst(rst), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_valid(input bit sel);
    return sel ? if32.oValid : if16.oValid;
  endfunction
  function automatic logic get_ready(input bit sel);
    return sel ? if32.oReady : if16.oReady;
  endfunction
  function automatic logic get_err(input bit sel);
    return sel ? if32.oErr : if16.oErr;
  endfunction
  function automatic logic [31:0] get_c(input bit sel);
    return sel ? if32.oC : {16'h0, if16.oC};
  endfunction

  task automatic drive(input bit sel, input logic vld, input logic mode,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      if32.iValid = vld; if32.iMode = mode; if32.iA = a; if32.iB = b;
    end else begin
      if16.iValid = vld; if16.iMode = mode; if16.iA = a[15:0]; if16.iB = b[15:0];
    end
  endtask

  // Returns at the falling edge right after the accept edge.
  task automatic start_req(input bit sel, input logic mode, input logic [31:0] a,
                           input logic [31:0] b);
    @(negedge clk);
    drive(sel, 1'b1, mode, a, b);
    @(negedge clk);
    drive(sel, 1'b0, mode, a, b);
    acc = cyc;
  endtask

  task automatic finish_req(input bit sel, output logic [31:0] c, output logic err,
                            output int lat);
    int bound;
    bound = max_iter(sel ? 32 : 16) + 4;
    while (!get_valid(sel) && (cyc - acc + 1) < bound) @(negedge clk);
    lat = cyc - acc + 1;
    check("valid_seen", get_valid(sel), 1'b1);
    c   = get_c(sel);
    err = get_err(sel);
    @(negedge clk);
    check("pulse_width", get_valid(sel), 1'b0);
    check("result_held", get_c(sel), c);
  endtask

  task automatic do_req(input bit sel, input logic mode, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] c, output logic err,
                        output int lat);
    start_req(sel, mode, a, b);
    finish_req(sel, c, err, lat);
  endtask

  // Reference: plain Euclid by remainder.
  function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b; a = b; b = t;
    end
    return a;
  endfunction

  // Reference: extended Euclid on signed integers.
  task automatic ref_inv(input longint a, input longint b, output logic [31:0] val,
                         output logic err);
    longint old_r, r, old_s, s, q, t;
    val = '0;
    err = 1'b1;
    if (b < 2 || (b % 2) == 0) return;
    old_r = a % b; r = b; old_s = 1; s = 0;
    while (r != 0) begin
      q = old_r / r;
      t = old_r - q * r; old_r = r; r = t;
      t = old_s - q * s; old_s = s; s = t;
    end
    if (old_r != 1) return;
    err = 1'b0;
    val = 32'(((old_s % b) + b) % b);
  endtask

  logic [31:0] c, exp_c, prev_c, ra, rb;
  logic        e, exp_e, mode, seen;
  int          lat;
  logic [15:0] gt_a [8] = '{16'd31, 16'd1323, 16'd23532, 16'd0, 16'd0, 16'd48, 16'd65535, 16'd32768};
  logic [15:0] gt_b [8] = '{16'd3, 16'd612, 16'd544, 16'd0, 16'd77, 16'd0, 16'd65535, 16'd16384};
  logic [15:0] gt_c [8] = '{16'd1, 16'd9, 16'd4, 16'd0, 16'd77, 16'd48, 16'd65535, 16'd16384};

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst_ready", if16.oReady, 1'b1);
    check("rst_valid", if16.oValid, 1'b0);
    check("rst_c", if16.oC, 16'h0);
    check("rst_err", if16.oErr, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, MODE_GCD, 32'(gt_a[i]), 32'(gt_b[i]), c, e, lat);
      check("gcd16_c", c, 32'(gt_c[i]));
      check("gcd16_err", e, 1'b0);
      if (i == 4) check("gcd_0n_latency", lat, 3);
    end

    do_req(1'b0, MODE_INV, 32'd3, 32'd31, c, e, lat);
    check("inv_3_31", c, 32'd21);
    check("inv_3_31_err", e, 1'b0);

    do_req(1'b0, MODE_INV, 32'd1323, 32'd65521, c, e, lat);
    ref_inv(1323, 65521, exp_c, exp_e);
    check("inv_1323_c", c, exp_c);
    check("inv_1323_prod", (64'(c) * 64'd1323) % 64'd65521, 64'd1);
    check("inv_1323_err", e, 1'b0);

    do_req(1'b0, MODE_INV, 32'd6, 32'd9, c, e, lat);
    check("inv_6_9_err", e, 1'b1);
    check("inv_6_9_c", c, 32'd0);

    do_req(1'b0, MODE_INV, 32'd5, 32'd10, c, e, lat);
    check("inv_even_err", e, 1'b1);
    check("inv_even_c", c, 32'd0);
    check("inv_even_fast", lat <= 2, 1'b1);

    do_req(1'b0, MODE_INV, 32'd5, 32'd1, c, e, lat);
    check("inv_one_err", e, 1'b1);
    check("inv_one_c", c, 32'd0);
    check("inv_one_fast", lat <= 2, 1'b1);

    // Requests presented while busy must be dropped.
    prev_c = get_c(1'b0);
    start_req(1'b0, MODE_GCD, 32'd65535, 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, MODE_INV, 32'd9, 32'd3);
      check("busy_ready", if16.oReady, 1'b0);
      check("busy_c_held", get_c(1'b0), prev_c);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, MODE_GCD, 32'd0, 32'd0);
    finish_req(1'b0, c, e, lat);
    check("busy_result", c, 32'd1);
    check("busy_result_err", e, 1'b0);
    @(negedge clk);
    check("busy_no_replay", if16.oValid, 1'b0);

    // Asynchronous reset in the middle of a computation.
    start_req(1'b0, MODE_GCD, 32'd65535, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_ready", if16.oReady, 1'b1);
    check("arst_valid", if16.oValid, 1'b0);
    check("arst_c", if16.oC, 16'h0);
    check("arst_err", if16.oErr, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (90) begin
      @(negedge clk);
      if (if16.oValid) seen = 1'b1;
    end
    check("arst_no_valid", seen, 1'b0);
    do_req(1'b0, MODE_GCD, 32'd1323, 32'd612, c, e, lat);
    check("arst_next_req", c, 32'd9);

    for (int i = 0; i < 40; i++) begin
      mode = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (mode == MODE_INV && $urandom_range(0, 3) != 0) rb[0] = 1'b1;
      if ($urandom_range(0, 4) == 0) ra = ra >> $urandom_range(8, 31);
      if (mode == MODE_GCD && $urandom_range(0, 3) == 0) begin
        ra = ra << 5; rb = rb << 3;
      end
      do_req(1'b1, mode, ra, rb, c, e, lat);
      if (mode == MODE_GCD) begin
        exp_c = 32'(ref_gcd(64'(ra), 64'(rb)));
        exp_e = 1'b0;
      end else begin
        ref_inv(longint'(ra), longint'(rb), exp_c, exp_e);
      end
      check("rnd32_c", c, exp_c);
      check("rnd32_err", e, exp_e);
      check("rnd32_latency", (lat - 1) <= max_iter(32), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
